// File: rtl/sha256_pkg.sv
// Shared SHA-256 datapath constants and the accumulator state encoding.
package sha256_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } acc_state_t;

endpackage

// File: rtl/carry_save_adder.sv
// 3:2 carry-save compressor; carry is returned unshifted.
module carry_save_adder
  import sha256_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand modulo-2^WIDTH adder, running total kept in carry-save form.
// Optional operand counter and out_count port: define CSA_ACC_COUNT_EN.
module csa_accumulator
  import sha256_pkg::*;
#(
  parameter int WIDTH = DATA_W
`ifdef CSA_ACC_COUNT_EN
  ,
  parameter int CNT_W = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef CSA_ACC_COUNT_EN
  output logic [CNT_W-1:0] out_count,
`endif
  output logic             busy
);

  acc_state_t       state;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic [WIDTH-1:0] ps;
  logic [WIDTH-1:0] cy;
  logic             started;
  logic             accept;

`ifdef CSA_ACC_COUNT_EN
  logic [CNT_W-1:0] cnt;
`endif

  carry_save_adder #(
    .WIDTH(WIDTH)
  ) u_csa (
    .a    (sum_q),
    .b    (carry_q),
    .c    (in_data),
    .sum  (ps),
    .carry(cy)
  );

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != ACCUM) || started;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      sum_q     <= '0;
      carry_q   <= '0;
      started   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef CSA_ACC_COUNT_EN
      cnt       <= '0;
      out_count <= '0;
`endif
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            sum_q   <= ps;
            // carry out of the MSB falls off the shift: arithmetic is mod 2^WIDTH
            carry_q <= cy << 1;
            started <= 1'b1;
`ifdef CSA_ACC_COUNT_EN
            if (cnt != '1) cnt <= cnt + 1'b1;
`endif
            if (in_last) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_data  <= sum_q + carry_q;
          out_valid <= 1'b1;
`ifdef CSA_ACC_COUNT_EN
          out_count <= cnt;
`endif
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sum_q     <= '0;
            carry_q   <= '0;
            started   <= 1'b0;
`ifdef CSA_ACC_COUNT_EN
            cnt       <= '0;
            out_count <= '0;
`endif
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator with a per-cycle reference model.
module tb_csa_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;
`ifdef CSA_ACC_COUNT_EN
  logic [3:0]  out_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  csa_accumulator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
`ifdef CSA_ACC_COUNT_EN
    .out_count(out_count),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: packet total is the plain sum of accepted operands.
  // phase 0 = taking operands, 1 = one cycle of resolve, 2 = presenting.
  int          m_phase;
  int          m_n;
  logic [31:0] m_sum;
  logic [31:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_n     = 0;
      m_sum   = '0;
      m_res   = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_sum = m_sum + in_data;
          m_n++;
          if (in_last) m_phase = 1;
        end
        1: begin
          m_res   = m_sum;
          m_phase = 2;
        end
        default: if (out_ready) begin
          m_phase = 0;
          m_n     = 0;
          m_sum   = '0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_phase == 0});
      chk("busy", {31'd0, busy}, {31'd0, (m_phase != 0) || (m_n > 0)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
      if (m_phase == 2) chk("out_data_model", out_data, m_res);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic get_result(input string name, input logic [31:0] exp,
                            input int hold, input logic [3:0] exp_cnt);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      step();
      cyc++;
    end
    chk({name, "_latency"}, cyc, 1);
    chk({name, "_data"}, out_data, exp);
`ifdef CSA_ACC_COUNT_EN
    chk({name, "_count"}, {28'd0, out_count}, {28'd0, exp_cnt});
`else
    if (exp_cnt == 4'hF) $display("note: count value unused");
`endif
    for (int i = 0; i < hold; i++) begin
      step();
      chk({name, "_hold_data"}, out_data, exp);
      chk({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    step();

    beat(32'hDEADBEEF, 1'b1);
    get_result("single", 32'hDEADBEEF, 0, 4'd1);

    for (int i = 0; i < 5; i++) beat(32'hFFFFFFFF, i == 4);
    get_result("five_ff", 32'hFFFFFFFB, 0, 4'd5);

    beat(32'h80000000, 1'b0);
    beat(32'h80000000, 1'b1);
    get_result("wrap", 32'h00000000, 0, 4'd2);

    beat(32'd1, 1'b0);
    beat(32'd2, 1'b1);
    get_result("hold", 32'd3, 3, 4'd2);
    beat(32'd5, 1'b0);
    beat(32'd6, 1'b1);
    get_result("clear", 32'd11, 0, 4'd2);

    beat(32'h10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("gap_busy", {31'd0, busy}, 32'd1);
    end
    beat(32'h20, 1'b1);
    get_result("gap", 32'h30, 0, 4'd2);

    // back-to-back packets with out_ready already high
    out_ready = 1'b1;
    beat(32'h1234, 1'b1);
    step();
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_data", out_data, 32'h1234);
    step();
    chk("b2b_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;

    beat(32'h100, 1'b0);
    beat(32'h200, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    beat(32'd7, 1'b1);
    get_result("after_rst", 32'd7, 0, 4'd1);

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
